reset_stage_sequencer: RTL and testbench

Staged reset release for the modulator datapath. Takes the single global reset and releases per-stage active-low resets one stage at a time (for example NCO, then modulator core, then DAC interface). Each release waits for that stage's ready acknowledge, then a guard gap, before the next stage is released. Sits directly downstream of the power-on/first-clock reset generator and upstream of every datapath block.

---
 rtl/reset_stage_sequencer_pkg.sv | 27 ++
 rtl/reset_stage_sequencer_if.sv | 23 ++
 rtl/reset_stage_sequencer_seq_down_counter.sv | 25 ++
 rtl/reset_stage_sequencer.sv | 173 +++++++++++++++++
 tb/tb_reset_stage_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_stage_sequencer_pkg.sv
// Shared types and constants for the staged reset sequencer and the datapath top.
package reset_stage_sequencer_pkg;

    localparam int DEF_NUM_STAGES  = 3;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_STAGE_DELAY = 8;
    localparam int DEF_ACK_TIMEOUT = 32;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_RUN,
        ST_FAULT
    } seq_state_e;

    // One counter serves every phase, so it must hold the largest terminal value.
    function automatic int cnt_width(input int hold, input int gap, input int tmo);
        int m;
        m = hold;
        if (gap > m) m = gap;
        if (tmo > m) m = tmo;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_stage_sequencer_if.sv
// Handshake bundle between the reset sequencer (master) and the datapath stages (slave).
interface reset_stage_sequencer_if
    import reset_stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES
);
    logic                  soft_rst_req;
    logic [NUM_STAGES-1:0] stage_ack;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  all_ready;
    logic                  fault;
    logic [2:0]            fault_stage;

    modport master (
        input  soft_rst_req, stage_ack,
        output stage_rst_n, all_ready, fault, fault_stage
    );

    modport slave (
        output soft_rst_req, stage_ack,
        input  stage_rst_n, all_ready, fault, fault_stage
    );
endinterface

// File: rtl/reset_stage_sequencer_seq_down_counter.sv
// Loadable down-counter that saturates at zero; shared by the hold, gap and timeout phases.
module seq_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/reset_stage_sequencer.sv
// Staged per-stage reset release with ack wait and guard gap.
// Build option: define ACK_TIMEOUT_EN to add the ack timeout counter and FAULT state.
//
// state      | meaning
// HOLD       | all stages in reset, counting the initial hold
// RELEASE    | release stage idx
// WAIT_ACK   | waiting for stage_ack[idx]
// GAP        | guard delay before releasing the next stage
// RUN        | every stage released and acked
// FAULT      | stage idx missed its ack; idx and above held in reset
module reset_stage_sequencer
    import reset_stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input logic                     clk,
    input logic                     rst,
    reset_stage_sequencer_if.master bus
);
    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT);
    localparam logic [CW-1:0] HOLD_LD  = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] GAP_LD   = CW'((STAGE_DELAY > 0) ? STAGE_DELAY - 1 : 0);
    localparam logic [2:0]    LAST_IDX = 3'(NUM_STAGES - 1);

    seq_state_e            state, state_nxt;
    logic [2:0]            idx, idx_nxt;
    logic                  hold_armed, hold_armed_nxt;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_nxt;
    logic                  all_ready_q, all_ready_nxt;
    logic                  ack_cur;
    logic                  cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]         cnt_val;
`ifdef ACK_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LD = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    logic                  fault_q, fault_nxt;
    logic [2:0]            fault_stage_q, fault_stage_nxt;
`endif

    seq_down_counter #(.WIDTH(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        ack_cur = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (3'(i) == idx) ack_cur = bus.stage_ack[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_HOLD;
            idx           <= '0;
            hold_armed    <= 1'b0;
            rst_n_q       <= '0;
            all_ready_q   <= 1'b0;
`ifdef ACK_TIMEOUT_EN
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
`endif
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            hold_armed    <= hold_armed_nxt;
            rst_n_q       <= rst_n_nxt;
            all_ready_q   <= all_ready_nxt;
`ifdef ACK_TIMEOUT_EN
            fault_q       <= fault_nxt;
            fault_stage_q <= fault_stage_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        hold_armed_nxt = hold_armed;
        rst_n_nxt      = rst_n_q;
        cnt_load       = 1'b0;
        cnt_val        = '0;
        cnt_dec        = 1'b0;
`ifdef ACK_TIMEOUT_EN
        fault_nxt       = fault_q;
        fault_stage_nxt = fault_stage_q;
`endif
        if (bus.soft_rst_req) begin
            state_nxt      = ST_HOLD;
            idx_nxt        = '0;
            hold_armed_nxt = 1'b0;
            rst_n_nxt      = '0;
`ifdef ACK_TIMEOUT_EN
            fault_nxt       = 1'b0;
            fault_stage_nxt = '0;
`endif
        end else begin
            case (state)
                ST_HOLD: begin
                    // The first HOLD cycle arms the counter, so reset and soft restart time alike.
                    if (!hold_armed) begin
                        cnt_load       = 1'b1;
                        cnt_val        = HOLD_LD;
                        hold_armed_nxt = 1'b1;
                    end else if (cnt_zero) begin
                        state_nxt = ST_RELEASE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (3'(i) == idx) rst_n_nxt[i] = 1'b1;
                    end
`ifdef ACK_TIMEOUT_EN
                    cnt_load = 1'b1;
                    cnt_val  = TMO_LD;
`endif
                    state_nxt = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_cur) begin
                        if (idx == LAST_IDX) begin
                            state_nxt = ST_RUN;
                        end else begin
                            state_nxt = ST_GAP;
                            cnt_load  = 1'b1;
                            cnt_val   = GAP_LD;
                        end
                    end
`ifdef ACK_TIMEOUT_EN
                    else if (cnt_zero) begin
                        state_nxt       = ST_FAULT;
                        fault_nxt       = 1'b1;
                        fault_stage_nxt = idx;
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (3'(i) >= idx) rst_n_nxt[i] = 1'b0;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = ST_RELEASE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        all_ready_nxt = (state == ST_RUN) && (state_nxt == ST_RUN);
    end

    assign bus.stage_rst_n = rst_n_q;
    assign bus.all_ready   = all_ready_q;
`ifdef ACK_TIMEOUT_EN
    assign bus.fault       = fault_q;
    assign bus.fault_stage = fault_stage_q;
`else
    assign bus.fault       = 1'b0;
    assign bus.fault_stage = 3'b000;
`endif
endmodule

// File: tb/tb_reset_stage_sequencer.sv
// Bench for reset_stage_sequencer: timing table, corner sequences and a randomized run vs a timeline model.
module tb_reset_stage_sequencer;
    import reset_stage_sequencer_pkg::*;

    localparam int NS = 3;
    localparam int HC = 4;
    localparam int SD = 8;
    localparam int AT = 32;
`ifdef ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    reset_stage_sequencer_if #(.NUM_STAGES(NS)) bus ();

    reset_stage_sequencer #(
        .NUM_STAGES (NS),
        .HOLD_CYCLES(HC),
        .STAGE_DELAY(SD),
        .ACK_TIMEOUT(AT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ed;
        logic [NS-1:0] ack;
        logic [NS-1:0] exp_rst_n;
        bit          exp_ready;
    } vec_t;

    vec_t tbl[10];

    int n_vec;
    int n_err;
    int cyc;

    // Timeline model: each stage release is an absolute edge number derived from the timing rules.
    logic [NS-1:0] m_rst;
    bit            m_ready;
    bit            m_fault;
    int            m_fs;
    int            m_cur;
    int            m_rel_at;
    int            m_wait_start;
    int            m_ready_at;
    bit            m_waiting;
    bit            m_done;
    bit            m_faulted;

    task automatic model_edge();
        if (!rst || bus.soft_rst_req) begin
            m_rst      = '0;
            m_ready    = 1'b0;
            m_fault    = 1'b0;
            m_fs       = 0;
            m_cur      = 0;
            m_waiting  = 1'b0;
            m_done     = 1'b0;
            m_faulted  = 1'b0;
            m_rel_at   = cyc + HC + 2;
            m_ready_at = -1;
        end else if (m_waiting) begin
            if (bus.stage_ack[m_cur] === 1'b1) begin
                m_waiting = 1'b0;
                if (m_cur == NS - 1) begin
                    m_done     = 1'b1;
                    m_ready_at = cyc + 1;
                end else begin
                    m_cur    = m_cur + 1;
                    m_rel_at = cyc + SD + 1;
                end
            end else if (TO_EN && (cyc == m_wait_start + AT)) begin
                m_waiting      = 1'b0;
                m_faulted      = 1'b1;
                m_fault        = 1'b1;
                m_fs           = m_cur;
                m_rst[m_cur]   = 1'b0;
            end
        end else if (!m_done && !m_faulted && (cyc == m_rel_at)) begin
            m_rst[m_cur]  = 1'b1;
            m_waiting     = 1'b1;
            m_wait_start  = cyc;
        end
        if (m_done && (cyc == m_ready_at)) m_ready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        cyc = cyc + 1;
        model_edge();
        #1;
        n_vec = n_vec + 1;
        if (bus.stage_rst_n !== m_rst || bus.all_ready !== m_ready ||
            bus.fault !== m_fault || int'(bus.fault_stage) != m_fs) begin
            n_err = n_err + 1;
            if (n_err <= 20)
                $display("FAIL model@%0d: got rst_n=%b ready=%b fault=%b fs=%0d, expected rst_n=%b ready=%b fault=%b fs=%0d",
                         cyc, bus.stage_rst_n, bus.all_ready, bus.fault, bus.fault_stage,
                         m_rst, m_ready, m_fault, m_fs);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_release(input int i, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget && at < 0; k++) begin
            step();
            if (bus.stage_rst_n[i] === 1'b1) at = cyc;
        end
        n_vec = n_vec + 1;
        if (at < 0) begin
            n_err = n_err + 1;
            $display("FAIL wait_release%0d: no release within %0d cycles", i, budget);
        end
    endtask

    task automatic run_table(input int base);
        for (int r = 0; r < 10; r++) begin
            bus.stage_ack = tbl[r].ack;
            while (cyc < base + tbl[r].ed) step();
            check($sformatf("tbl%0d_rst_n", r), int'(bus.stage_rst_n), int'(tbl[r].exp_rst_n));
            check($sformatf("tbl%0d_ready", r), int'(bus.all_ready), int'(tbl[r].exp_ready));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rel1;
        int rel2;
        int na;
        int w;
        int got;

        tbl[0] = '{0,  3'b111, 3'b000, 1'b0};
        tbl[1] = '{4,  3'b111, 3'b000, 1'b0};
        tbl[2] = '{5,  3'b111, 3'b001, 1'b0};
        tbl[3] = '{14, 3'b111, 3'b001, 1'b0};
        tbl[4] = '{15, 3'b111, 3'b011, 1'b0};
        tbl[5] = '{24, 3'b111, 3'b011, 1'b0};
        tbl[6] = '{25, 3'b111, 3'b111, 1'b0};
        tbl[7] = '{26, 3'b111, 3'b111, 1'b0};
        tbl[8] = '{27, 3'b111, 3'b111, 1'b1};
        tbl[9] = '{35, 3'b111, 3'b111, 1'b1};

        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b0;
        bus.soft_rst_req = 1'b0;
        bus.stage_ack    = '0;

        step();
        step();
        check("reset_rst_n", int'(bus.stage_rst_n), 0);
        check("reset_ready", int'(bus.all_ready), 0);
        check("reset_fault", int'(bus.fault), 0);
        check("reset_fs",    int'(bus.fault_stage), 0);

        rst  = 1'b1;
        base = cyc + 1;
        run_table(base);

        // soft re-sequence from RUN repeats identical timing
        bus.soft_rst_req = 1'b1;
        step();
        bus.soft_rst_req = 1'b0;
        check("soft_rst_n", int'(bus.stage_rst_n), 0);
        check("soft_ready", int'(bus.all_ready), 0);
        base = cyc + 1;
        run_table(base);

        // hard reset in the middle of the first gap
        rst = 1'b0;
        step();
        rst  = 1'b1;
        base = cyc + 1;
        while (cyc < base + 10) step();
        check("gap_rst_n", int'(bus.stage_rst_n), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midgap_rst_n", int'(bus.stage_rst_n), 0);
        check("midgap_ready", int'(bus.all_ready), 0);
        base = cyc + 1;
        run_table(base);

        // late ack on stage 1
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.stage_ack = 3'b101;
        wait_release(1, 100, rel1);
        repeat (9) step();
        bus.stage_ack = 3'b111;
        na = cyc + 1;
        wait_release(2, 100, rel2);
        check("late_ack_gap", rel2, na + SD + 1);
        check("late_ack_fault", int'(bus.fault), 0);

`ifdef ACK_TIMEOUT_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.stage_ack = 3'b001;
        wait_release(1, 100, w);
        repeat (AT - 1) step();
        check("tmo_early_fault", int'(bus.fault), 0);
        step();
        check("tmo_fault", int'(bus.fault), 1);
        check("tmo_stage", int'(bus.fault_stage), 1);
        check("tmo_rst_n", int'(bus.stage_rst_n), 1);
        bus.stage_ack = 3'b111;
        repeat (5) step();
        check("tmo_sticky", int'(bus.fault), 1);
        bus.soft_rst_req = 1'b1;
        step();
        bus.soft_rst_req = 1'b0;
        check("tmo_clear", int'(bus.fault), 0);
`else
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.stage_ack = 3'b000;
        wait_release(0, 100, w);
        repeat (1000) step();
        check("noto_fault", int'(bus.fault), 0);
        check("noto_rst_n", int'(bus.stage_rst_n), 1);
        bus.stage_ack = 3'b111;
        got = 0;
        for (int k = 0; k < 100 && got == 0; k++) begin
            step();
            if (bus.all_ready === 1'b1) got = 1;
        end
        check("noto_ready", got, 1);
`endif

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15) == 0) bus.stage_ack = NS'($urandom | $urandom);
            bus.soft_rst_req = ($urandom_range(299) == 0);
            rst = ($urandom_range(799) != 0);
            step();
        end
        bus.soft_rst_req = 1'b0;
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
